// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
//   ctrl_state_t      : controller state encoding (also exported on o_ctrl_state for debug)
//   REGISTER_SIZE_DEF : default register address width
package pipeline_ctrl_pkg;

   localparam int unsigned REGISTER_SIZE_DEF = 5;

   typedef enum logic [2:0] {
      STARTUP    = 3'd0,
      RUN        = 3'd1,
      LOAD_STALL = 3'd2,
      REDIRECT   = 3'd3,
      EX_WAIT    = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/pipeline_controller_load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the execute stage holds a load whose (non-x0) destination is read
// by the valid instruction currently in decode.
//   i_d_valid, i_d_rs1_used, i_d_rs2_used, i_d_rs1_addr, i_d_rs2_addr : decode fields
//   i_e_valid, i_e_dm_read_enable, i_e_rd_addr                        : execute fields
//   o_load_use                                                        : hazard present
module load_use_detect
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REGISTER_SIZE = REGISTER_SIZE_DEF
) (
   input  logic                     i_d_valid,
   input  logic                     i_d_rs1_used,
   input  logic                     i_d_rs2_used,
   input  logic [REGISTER_SIZE-1:0] i_d_rs1_addr,
   input  logic [REGISTER_SIZE-1:0] i_d_rs2_addr,
   input  logic                     i_e_valid,
   input  logic                     i_e_dm_read_enable,
   input  logic [REGISTER_SIZE-1:0] i_e_rd_addr,
   output logic                     o_load_use
);

   logic w_e_load;
   logic w_rs1_hit;
   logic w_rs2_hit;

   // x0 is never a real producer, so loads targeting it cannot cause a hazard
   assign w_e_load   = i_e_valid & i_e_dm_read_enable & (i_e_rd_addr != '0);
   assign w_rs1_hit  = i_d_rs1_used & (i_d_rs1_addr == i_e_rd_addr);
   assign w_rs2_hit  = i_d_rs2_used & (i_d_rs2_addr == i_e_rd_addr);
   assign o_load_use = w_e_load & i_d_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Central hazard and sequencing controller for the five-stage core.
// Drives PC / stage-register enables and bubble flushes from the decode and
// execute stage state; keeps saturating stall and flush performance counters.
//   i_clk, i_rst (async, active high)
//   i_d_*            : decode stage status (valid, sources, taken redirect)
//   i_e_*            : execute stage status (valid, load, destination)
//   i_ex_busy        : multi-cycle execute unit not finished
//   i_cnt_clear      : synchronous clear of both counters
//   o_pc_enable, o_f_to_d_enable_ff, o_d_to_e_enable_ff, o_f_to_d_flush, o_d_to_e_flush
//   o_stall_count, o_flush_count : performance counters
//   o_ctrl_state     : current state encoding (debug)
module pipeline_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REGISTER_SIZE = REGISTER_SIZE_DEF,
   parameter int unsigned RESET_HOLD    = 2,
   parameter int unsigned CNT_WIDTH     = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_d_valid,
   input  logic                     i_d_rs1_used,
   input  logic                     i_d_rs2_used,
   input  logic [REGISTER_SIZE-1:0] i_d_rs1_addr,
   input  logic [REGISTER_SIZE-1:0] i_d_rs2_addr,
   input  logic                     i_d_redirect,
   input  logic                     i_e_valid,
   input  logic                     i_e_dm_read_enable,
   input  logic [REGISTER_SIZE-1:0] i_e_rd_addr,
   input  logic                     i_ex_busy,
   input  logic                     i_cnt_clear,
   output logic                     o_pc_enable,
   output logic                     o_f_to_d_enable_ff,
   output logic                     o_d_to_e_enable_ff,
   output logic                     o_f_to_d_flush,
   output logic                     o_d_to_e_flush,
   output logic [CNT_WIDTH-1:0]     o_stall_count,
   output logic [CNT_WIDTH-1:0]     o_flush_count,
   output logic [2:0]               o_ctrl_state
);

   localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

   ctrl_state_t           r_state;
   ctrl_state_t           w_state_d;
   logic [HOLD_W-1:0]     r_hold;
   logic [HOLD_W-1:0]     w_hold_d;
   logic [CNT_WIDTH-1:0]  r_stall_cnt;
   logic [CNT_WIDTH-1:0]  r_flush_cnt;
   logic                  w_load_use;
   logic                  w_lu_eff;
   logic                  w_rd_eff;
   logic                  w_stall_inc;
   logic                  w_flush_inc;

   load_use_detect #(
      .REGISTER_SIZE (REGISTER_SIZE)
   ) u_load_use_detect (
      .i_d_valid          (i_d_valid),
      .i_d_rs1_used       (i_d_rs1_used),
      .i_d_rs2_used       (i_d_rs2_used),
      .i_d_rs1_addr       (i_d_rs1_addr),
      .i_d_rs2_addr       (i_d_rs2_addr),
      .i_e_valid          (i_e_valid),
      .i_e_dm_read_enable (i_e_dm_read_enable),
      .i_e_rd_addr        (i_e_rd_addr),
      .o_load_use         (w_load_use)
   );

   // One-cycle masks: after a load stall the value is forwarded from memory;
   // after a redirect the decode slot holds the bubble.
   assign w_lu_eff = w_load_use & (r_state != LOAD_STALL);
   assign w_rd_eff = i_d_valid & i_d_redirect & (r_state != REDIRECT);

   always_comb begin
      w_state_d          = r_state;
      w_hold_d           = r_hold;
      o_pc_enable        = 1'b1;
      o_f_to_d_enable_ff = 1'b1;
      o_d_to_e_enable_ff = 1'b1;
      o_f_to_d_flush     = 1'b0;
      o_d_to_e_flush     = 1'b0;
      w_stall_inc        = 1'b0;
      w_flush_inc        = 1'b0;

      case (r_state)
         STARTUP: begin
            o_pc_enable    = 1'b0;
            o_f_to_d_flush = 1'b1;
            o_d_to_e_flush = 1'b1;
            if (r_hold == '0) begin
               w_state_d = RUN;
            end else begin
               w_hold_d = r_hold - 1'b1;
            end
         end
         // RUN, LOAD_STALL, REDIRECT and EX_WAIT share one priority chain;
         // EX_WAIT with ex_busy low behaves exactly like RUN.
         default: begin
            if (i_ex_busy) begin
               o_pc_enable        = 1'b0;
               o_f_to_d_enable_ff = 1'b0;
               o_d_to_e_enable_ff = 1'b0;
               w_stall_inc        = 1'b1;
               w_state_d          = EX_WAIT;
            end else if (w_lu_eff) begin
               o_pc_enable        = 1'b0;
               o_f_to_d_enable_ff = 1'b0;
               o_d_to_e_flush     = 1'b1;
               w_stall_inc        = 1'b1;
               w_state_d          = LOAD_STALL;
            end else if (w_rd_eff) begin
               o_f_to_d_flush = 1'b1;
               w_flush_inc    = 1'b1;
               w_state_d      = REDIRECT;
            end else begin
               w_state_d = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= STARTUP;
         r_hold  <= HOLD_INIT;
      end else begin
         r_state <= w_state_d;
         r_hold  <= w_hold_d;
      end
   end

   // Saturating counters; clear beats a same-cycle increment.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (i_cnt_clear) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_inc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         end
         if (w_flush_inc && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign o_stall_count = r_stall_cnt;
   assign o_flush_count = r_flush_cnt;
   assign o_ctrl_state  = r_state;

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

   localparam int RH  = 2;
   localparam int CW  = 4;
   localparam int RS  = 5;
   localparam int SAT = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          d_valid, d_rs1_used, d_rs2_used, d_redirect;
   logic [RS-1:0] d_rs1_addr, d_rs2_addr, e_rd_addr;
   logic          e_valid, e_dm_read_enable, ex_busy, cnt_clear;
   logic          pc_enable, f_to_d_en, d_to_e_en, f_to_d_flush, d_to_e_flush;
   logic [CW-1:0] stall_count, flush_count;
   logic [2:0]    ctrl_state;

   pipeline_controller #(
      .REGISTER_SIZE (RS),
      .RESET_HOLD    (RH),
      .CNT_WIDTH     (CW)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_d_valid          (d_valid),
      .i_d_rs1_used       (d_rs1_used),
      .i_d_rs2_used       (d_rs2_used),
      .i_d_rs1_addr       (d_rs1_addr),
      .i_d_rs2_addr       (d_rs2_addr),
      .i_d_redirect       (d_redirect),
      .i_e_valid          (e_valid),
      .i_e_dm_read_enable (e_dm_read_enable),
      .i_e_rd_addr        (e_rd_addr),
      .i_ex_busy          (ex_busy),
      .i_cnt_clear        (cnt_clear),
      .o_pc_enable        (pc_enable),
      .o_f_to_d_enable_ff (f_to_d_en),
      .o_d_to_e_enable_ff (d_to_e_en),
      .o_f_to_d_flush     (f_to_d_flush),
      .o_d_to_e_flush     (d_to_e_flush),
      .o_stall_count      (stall_count),
      .o_flush_count      (flush_count),
      .o_ctrl_state       (ctrl_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: remaining start-up cycles, what the previous cycle did
   // (which decides the one-cycle masks), and the counter values.
   int m_left;
   int m_code;      // expected debug state: 0 start,1 run,2 load stall,3 redirect,4 ex wait
   int m_stall;
   int m_flush;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      d_valid = 0; d_rs1_used = 0; d_rs2_used = 0; d_redirect = 0;
      d_rs1_addr = '0; d_rs2_addr = '0;
      e_valid = 0; e_dm_read_enable = 0; e_rd_addr = '0;
      ex_busy = 0; cnt_clear = 0;
   endtask

   task automatic chk_outs(input int pc, input int fd, input int de, input int ffl,
                           input int dfl);
      chk("pc_enable", int'(pc_enable), pc);
      chk("f_to_d_enable", int'(f_to_d_en), fd);
      chk("d_to_e_enable", int'(d_to_e_en), de);
      chk("f_to_d_flush", int'(f_to_d_flush), ffl);
      chk("d_to_e_flush", int'(d_to_e_flush), dfl);
      chk("ctrl_state", int'(ctrl_state), m_code);
      chk("stall_count", int'(stall_count), m_stall);
      chk("flush_count", int'(flush_count), m_flush);
   endtask

   // One clock: check the combinational response to the current inputs, advance
   // the model, then move to 1 time unit past the next rising edge.
   task automatic cycle();
      bit lu, rd, s_inc, f_inc;
      int nxt;
      #2;
      s_inc = 0; f_inc = 0;
      if (m_code == 0) begin
         chk_outs(0, 1, 1, 1, 1);
         m_left = m_left - 1;
         nxt    = (m_left == 0) ? 1 : 0;
      end else begin
         lu = e_valid && e_dm_read_enable && (e_rd_addr != 0) && d_valid &&
              ((d_rs1_used && d_rs1_addr == e_rd_addr) ||
               (d_rs2_used && d_rs2_addr == e_rd_addr)) && (m_code != 2);
         rd = d_valid && d_redirect && (m_code != 3);
         if (ex_busy) begin
            chk_outs(0, 0, 0, 0, 0); s_inc = 1; nxt = 4;
         end else if (lu) begin
            chk_outs(0, 0, 1, 0, 1); s_inc = 1; nxt = 2;
         end else if (rd) begin
            chk_outs(1, 1, 1, 1, 0); f_inc = 1; nxt = 3;
         end else begin
            chk_outs(1, 1, 1, 0, 0); nxt = 1;
         end
      end
      if (cnt_clear) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (s_inc && m_stall < SAT) m_stall++;
         if (f_inc && m_flush < SAT) m_flush++;
      end
      @(posedge clk);
      #1;
      m_code = nxt;
   endtask

   // Asynchronous reset from wherever we are; returns at edge+1 with rst low.
   task automatic do_reset();
      rst = 1;
      #1;
      m_left = RH; m_code = 0; m_stall = 0; m_flush = 0;
      chk_outs(0, 1, 1, 1, 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      idle();
      rst = 0;
      do_reset();

      // Start-up: ctrl_state 0,0,1 and pc_enable 0,0,1
      repeat (3) cycle();

      // Load to x5, decode reads rs2=x5: single-cycle stall, then normal flow
      d_valid = 1; d_rs2_used = 1; d_rs2_addr = 5;
      e_valid = 1; e_dm_read_enable = 1; e_rd_addr = 5;
      cycle();
      cycle();
      idle();
      cycle();

      // Load to x0 with decode reading x0: no stall
      d_valid = 1; d_rs1_used = 1; d_rs1_addr = 0;
      e_valid = 1; e_dm_read_enable = 1; e_rd_addr = 0;
      cycle();
      idle();

      // Redirect held two cycles: second is ignored
      d_valid = 1; d_redirect = 1;
      cycle();
      cycle();
      idle();
      cycle();

      // Clear counters, then ex_busy 4 cycles over a pending load-use + redirect
      cnt_clear = 1;
      cycle();
      cnt_clear = 0;
      d_valid = 1; d_rs1_used = 1; d_rs1_addr = 7; d_redirect = 1;
      e_valid = 1; e_dm_read_enable = 1; e_rd_addr = 7;
      ex_busy = 1;
      repeat (4) cycle();
      ex_busy = 0;
      cycle();            // load-use stall
      e_valid = 0;
      cycle();            // redirect accepted in the masked stall cycle
      idle();
      cycle();

      // Saturation of stall_count, clear wins over increment
      ex_busy = 1;
      repeat (20) cycle();
      cnt_clear = 1;
      cycle();
      cnt_clear = 0;
      repeat (2) cycle();

      // Reset mid EX_WAIT, away from any clock edge
      #3;
      do_reset();
      idle();
      repeat (3) cycle();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         d_valid          = 1'($urandom_range(0, 1));
         d_rs1_used       = 1'($urandom_range(0, 1));
         d_rs2_used       = 1'($urandom_range(0, 1));
         d_rs1_addr       = RS'($urandom_range(0, 3));
         d_rs2_addr       = RS'($urandom_range(0, 3));
         d_redirect       = ($urandom_range(0, 3) == 0);
         e_valid          = 1'($urandom_range(0, 1));
         e_dm_read_enable = 1'($urandom_range(0, 1));
         e_rd_addr        = RS'($urandom_range(0, 3));
         ex_busy          = ($urandom_range(0, 4) == 0);
         cnt_clear        = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central hazard and sequencing controller for the five-stage core. It watches the decode and execute stages and drives the fetch-to-decode and decode-to-execute register enables, the PC enable and the bubble/flush controls. It resolves load-use stalls, jump/branch redirects, multi-cycle execute waits and post-reset start-up. It also keeps saturating stall and flush performance counters.

## Interface
- REGISTER_SIZE, 5, register address width
- RESET_HOLD, 2, cycles spent in STARTUP after reset release (≥1)
- CNT_WIDTH, 32, width of each performance counter

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- d_valid  in  1  decode stage holds a real instruction
- d_rs1_used, d_rs2_used  in  1 each  decode instruction reads rs1 / rs2
- d_rs1_addr, d_rs2_addr  in  REGISTER_SIZE each  decode source registers
- d_redirect  in  1  decode instruction is a taken jump or branch; JBL target is valid this cycle
- e_valid  in  1  execute stage holds a real instruction
- e_dm_read_enable  in  1  execute instruction is a load
- e_rd_addr  in  REGISTER_SIZE  execute destination register
- ex_busy  in  1  multi-cycle execute unit not finished
- cnt_clear  in  1  synchronous clear of both counters
- pc_enable  out  1  PC register load enable
- f_to_d_enable_ff  out  1  fetch-to-decode register enable
- d_to_e_enable_ff  out  1  decode-to-execute register enable
- f_to_d_flush  out  1  load a bubble into fetch-to-decode (qualified by its enable)
- d_to_e_flush  out  1  load a bubble into decode-to-execute (qualified by its enable)
- stall_count  out  CNT_WIDTH  cycles spent in ex-busy or load-use stall
- flush_count  out  CNT_WIDTH  redirects taken
- ctrl_state  out  3  current state encoding, for debug

## Operation
- States: STARTUP, RUN, LOAD_STALL, REDIRECT, EX_WAIT.
- load_use = e_valid & e_dm_read_enable & (e_rd_addr≠0) & d_valid & ((d_rs1_used & d_rs1_addr==e_rd_addr) | (d_rs2_used & d_rs2_addr==e_rd_addr)).
- STARTUP:
  - pc_enable=0, both enables=1, both flushes=1.
  - A down-counter loaded with RESET_HOLD-1 counts to 0, then the block enters RUN.
- Evaluation priority in RUN, LOAD_STALL and REDIRECT: ex_busy > load_use > d_redirect.
- ex_busy:
  - pc_enable=0, both enables=0, no flushes.
  - The block enters or stays in EX_WAIT and increments stall_count.
  - When ex_busy drops, outputs revert to RUN behaviour in that same cycle; the state returns to RUN.
- load_use:
  - pc_enable=0, f_to_d_enable_ff=0, d_to_e_enable_ff=1 with d_to_e_flush=1 (a bubble enters execute).
  - The block enters LOAD_STALL and increments stall_count.
  - In LOAD_STALL, load_use is masked for one cycle; the loaded value is forwarded from memory.
- d_redirect (with d_valid):
  - All enables=1, f_to_d_flush=1 to kill the sequentially fetched instruction.
  - The block enters REDIRECT and increments flush_count.
  - In REDIRECT, d_redirect is ignored for one cycle because the decode slot holds the bubble.
- No condition: all enables=1, no flushes, next state RUN.
- Counters:
  - Saturate at all-ones.
  - cnt_clear wins over a same-cycle increment.
  - Counters keep counting during STARTUP only if a stall or flush condition fires; STARTUP masks all three conditions, so none fire there.

## Timing
- All control outputs are combinational from the inputs and the state, so a hazard takes effect in the same cycle it is presented. State and counters update on the next rising edge.
- Reset (asynchronous, any time, including mid-stall):
  - State becomes STARTUP immediately and the hold counter reloads.
  - Outputs take STARTUP values: pc_enable=0, enables=1, flushes=1.
  - Counters reset to 0.
- Load-use penalty: exactly 1 cycle. Redirect penalty: exactly 1 cycle. EX_WAIT lasts as long as ex_busy is high.
- load_use and d_redirect together: the stall is taken first and the redirect is accepted in the following LOAD_STALL cycle.
- ex_busy rising during LOAD_STALL or REDIRECT: the block freezes in EX_WAIT and the mask is lost. The stage registers are frozen, so re-evaluation is safe.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - typedef enum logic [2:0] ctrl_state_t (STARTUP=0, RUN=1, LOAD_STALL=2, REDIRECT=3, EX_WAIT=4);
  - the default REGISTER_SIZE constant.
- Sub-module load_use_detect is purely combinational. It takes the decode/execute fields and produces load_use.
- Two instances of one saturating counter are acceptable inline; no further hierarchy.

## Test plan
- Reset release with RESET_HOLD=2 → pc_enable=0 for exactly 2 cycles, then 1. ctrl_state goes 0,0,1.
- Execute load with e_rd_addr=5 while decode reads rs2=5 → one cycle of pc_enable=0, f_to_d_enable_ff=0, d_to_e_flush=1; stall_count=1; next cycle normal flow.
- Load with e_rd_addr=0 while decode reads x0 → no stall.
- d_redirect pulse → f_to_d_flush=1 for one cycle; flush_count=1; a second d_redirect in the REDIRECT cycle is ignored.
- ex_busy high for 4 cycles while load_use and d_redirect are also asserted → all enables 0 for 4 cycles and stall_count=4. Then a load-use stall (stall_count=5), then the redirect (flush_count=1).
- Preload stall_count to all-ones via a long ex_busy with CNT_WIDTH=4 → holds at 15. cnt_clear together with an increment → 0. rst asserted mid-EX_WAIT → immediate STARTUP outputs.
